// File: rtl/s2mm_frame_streamer_if.sv
// AXI-Stream link from the frame streamer into the S2MM FIFO slave port.
interface s2mm_frame_streamer_if #(
  parameter int unsigned DATA_WIDTH = 16
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  // Streamer side drives payload and valid, sink returns ready.
  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  // FIFO side of the same link.
  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/s2mm_frame_streamer.sv
// S2MM transmit side: reads one frame from the output buffer (1-cycle read
// latency) and streams it as AXI-Stream with tlast on the final word. A
// 2-entry skid absorbs backpressure while sustaining 1 word/cycle.
module s2mm_frame_streamer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LEN_WIDTH  = 10
) (
  input  logic                  aclk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  words_sent,
  output logic                  buf_rd_en,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [DATA_WIDTH-1:0] buf_rd_data,
  s2mm_frame_streamer_if.master m
);

  localparam int unsigned CNT_WIDTH = 2;
  localparam int unsigned OCC_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic [LEN_WIDTH-1:0]  words_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  rd_rem_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  // Read pipeline: push_q marks that buf_rd_data carries a word this cycle.
  logic                  push_q;
  logic                  push_last_q;

  // Skid storage: entry 0 is the head presented on the stream.
  logic [CNT_WIDTH-1:0]  cnt_q,  cnt_d;
  logic [DATA_WIDTH-1:0] d0_q,   d0_d;
  logic [DATA_WIDTH-1:0] d1_q,   d1_d;
  logic                  l0_q,   l0_d;
  logic                  l1_q,   l1_d;
  logic                  valid_q;

  logic                  pop_c;
  logic                  rd_fire_c;
  logic                  rd_last_c;
  logic [OCC_WIDTH-1:0]  occ_c;

  // Read issue: only when the word is guaranteed a skid slot on return.
  always_comb begin
    pop_c     = valid_q & m.tready;
    occ_c     = OCC_WIDTH'(cnt_q) + OCC_WIDTH'(push_q) - OCC_WIDTH'(pop_c);
    rd_fire_c = 1'b0;
    if (!rst && (state_q == ST_STREAM) && (rd_rem_q != '0) &&
        (occ_c < OCC_WIDTH'(2))) begin
      rd_fire_c = 1'b1;
    end
    rd_last_c = rd_fire_c & (rd_rem_q == LEN_WIDTH'(1));
  end

  // Skid next-state: push from the buffer, pop on handshake, both keeps count.
  always_comb begin
    cnt_d = cnt_q;
    d0_d  = d0_q;
    d1_d  = d1_q;
    l0_d  = l0_q;
    l1_d  = l1_q;
    case ({push_q, pop_c})
      2'b10: begin
        if (cnt_q == CNT_WIDTH'(0)) begin
          d0_d = buf_rd_data;
          l0_d = push_last_q;
        end else begin
          d1_d = buf_rd_data;
          l1_d = push_last_q;
        end
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
      2'b01: begin
        d0_d  = d1_q;
        l0_d  = l1_q;
        l1_d  = 1'b0;
        cnt_d = cnt_q - CNT_WIDTH'(1);
      end
      2'b11: begin
        if (cnt_q == CNT_WIDTH'(1)) begin
          d0_d = buf_rd_data;
          l0_d = push_last_q;
        end else begin
          d0_d = d1_q;
          l0_d = l1_q;
          d1_d = buf_rd_data;
          l1_d = push_last_q;
        end
      end
      default: begin
      end
    endcase
  end

  // Skid and read-return registers.
  always_ff @(posedge aclk) begin
    if (rst) begin
      push_q      <= 1'b0;
      push_last_q <= 1'b0;
      cnt_q       <= '0;
      d0_q        <= '0;
      d1_q        <= '0;
      l0_q        <= 1'b0;
      l1_q        <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      push_q      <= rd_fire_c;
      push_last_q <= rd_last_c;
      cnt_q       <= cnt_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
      l0_q        <= l0_d;
      l1_q        <= l1_d;
      valid_q     <= (cnt_d != '0);
    end
  end

  // Frame control FSM with registered status outputs.
  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      words_q  <= '0;
      len_q    <= '0;
      rd_rem_q <= '0;
      addr_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            words_q <= '0;
            len_q   <= frame_len;
            if (frame_len != '0) begin
              state_q  <= ST_STREAM;
              busy_q   <= 1'b1;
              addr_q   <= base_addr;
              rd_rem_q <= frame_len;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (rd_fire_c) begin
            addr_q   <= addr_q + ADDR_WIDTH'(1);
            rd_rem_q <= rd_rem_q - LEN_WIDTH'(1);
          end
          if (pop_c && (words_q != len_q)) begin
            words_q <= words_q + LEN_WIDTH'(1);
          end
          if (pop_c && l0_q) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign words_sent  = words_q;
  assign buf_rd_en   = rd_fire_c;
  assign buf_rd_addr = addr_q;
  assign m.tdata     = d0_q;
  assign m.tvalid    = valid_q;
  assign m.tlast     = l0_q & valid_q;

endmodule

// File: tb/tb_s2mm_frame_streamer.sv
// Bench for s2mm_frame_streamer: directed vector table, reset/ignored-start
// sequences and randomized frames, all checked against a frame-level model.
`timescale 1ns/1ps
module tb_s2mm_frame_streamer;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 10;
  localparam int unsigned LW = 10;

  logic          aclk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] frame_len;
  logic          busy;
  logic          done;
  logic [LW-1:0] words_sent;
  logic          buf_rd_en;
  logic [AW-1:0] buf_rd_addr;
  logic [DW-1:0] buf_rd_data;

  always #5 aclk = ~aclk;

  s2mm_frame_streamer_if #(.DATA_WIDTH(DW)) m_if ();

  s2mm_frame_streamer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LEN_WIDTH (LW)
  ) dut (
    .aclk       (aclk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .frame_len  (frame_len),
    .busy       (busy),
    .done       (done),
    .words_sent (words_sent),
    .buf_rd_en  (buf_rd_en),
    .buf_rd_addr(buf_rd_addr),
    .buf_rd_data(buf_rd_data),
    .m          (m_if)
  );

  // Output buffer model with 1-cycle read latency.
  logic [DW-1:0] mem [0:1023];
  always @(posedge aclk) begin
    if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: expected words and bookkeeping of what was seen.
  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  bit            model_active = 0;
  bit            exp_done = 0;
  bit            after_rst = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [AW-1:0] exp_addr;
  int            exp_len = 0;
  int            n_rd = 0;
  int            n_hs = 0;
  int            rel = 0;
  int            first_rd = -1;
  int            first_valid = -1;
  int            done_rel = -1;

  // Ready driver: 0 = always ready, 1 = 1,0,0 pattern, 2 = random.
  int rmode = 0;
  int rcyc = 0;
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      rcyc++;
      case (rmode)
        0:       m_if.tready = 1'b1;
        1:       m_if.tready = ((rcyc % 3) == 0);
        default: m_if.tready = ($urandom_range(0, 99) < 70);
      endcase
    end
  end

  // Monitor and scoreboard, sampled mid-cycle.
  initial begin
    bit            done_cycle;
    bit            rd_allowed;
    exp_t          e;
    logic [AW-1:0] a;
    forever begin
      @(negedge aclk);
      if (rst) begin
        model_active = 0;
        exp_q.delete();
        exp_done     = 0;
        prev_stall   = 0;
        after_rst    = 1;
      end else begin
        rel++;
        if (after_rst) begin
          chk("valid_after_rst", 32'(m_if.tvalid), 0);
          after_rst = 0;
        end
        chk("done", 32'(done), 32'(exp_done));
        done_cycle = exp_done;
        if (done_cycle) begin
          chk("busy_at_done", 32'(busy), 0);
          done_rel     = rel;
          model_active = 0;
        end else if (model_active && exp_len != 0) begin
          chk("busy_in_frame", 32'(busy), 1);
        end
        exp_done = 0;

        rd_allowed = model_active && (n_rd < exp_len);
        if (!rd_allowed) chk("spurious_read", 32'(buf_rd_en), 0);
        else if (buf_rd_en) begin
          chk("rd_addr", 32'(buf_rd_addr), 32'(exp_addr));
          exp_addr = exp_addr + AW'(1);
          n_rd++;
          if (first_rd < 0) first_rd = rel;
        end

        if (prev_stall) begin
          chk("hold_valid", 32'(m_if.tvalid), 1);
          chk("hold_data", 32'(m_if.tdata), 32'(prev_data));
          chk("hold_last", 32'(m_if.tlast), 32'(prev_last));
        end
        if (!m_if.tvalid) chk("last_without_valid", 32'(m_if.tlast), 0);
        if (!model_active) chk("valid_when_idle", 32'(m_if.tvalid), 0);
        if (m_if.tvalid && first_valid < 0) first_valid = rel;
        if (m_if.tvalid && m_if.tready) begin
          if (exp_q.size() == 0) chk("extra_word", 32'(m_if.tvalid), 0);
          else begin
            e = exp_q.pop_front();
            chk("tdata", 32'(m_if.tdata), 32'(e.data));
            chk("tlast", 32'(m_if.tlast), 32'(e.last));
            n_hs++;
            if (e.last) exp_done = 1;
          end
        end
        if (model_active) chk("outstanding_le2", 32'((n_rd - n_hs) <= 2), 1);
        prev_stall = m_if.tvalid && !m_if.tready;
        prev_data  = m_if.tdata;
        prev_last  = m_if.tlast;

        if (start && !model_active && !done_cycle) begin
          model_active = 1;
          exp_len      = int'(frame_len);
          exp_addr     = base_addr;
          n_rd         = 0;
          n_hs         = 0;
          rel          = 0;
          first_rd     = -1;
          first_valid  = -1;
          done_rel     = -1;
          for (int i = 0; i < exp_len; i++) begin
            a      = base_addr + AW'(i);
            e.data = mem[a];
            e.last = (i == exp_len - 1);
            exp_q.push_back(e);
          end
          if (exp_len == 0) exp_done = 1;
        end
      end
    end
  end

  // Directed vector: inputs plus expected cycle markers (-1 never, -2 don't care).
  typedef struct {
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    int            mode;
    int            spur;
    int            e_rd;
    int            e_valid;
    int            e_done;
  } vec_t;

  task automatic run_vec(input vec_t v, input string name);
    int k;
    rmode = v.mode;
    @(posedge aclk);
    #1;
    start     = 1'b1;
    base_addr = v.base;
    frame_len = v.len;
    k = 0;
    forever begin
      @(posedge aclk);
      if (!model_active) break;
      if (k > 3000) begin
        chk({name, "_timeout"}, 32'(model_active), 0);
        break;
      end
      #1;
      k++;
      start = (k == v.spur);
      if (k == v.spur) begin
        base_addr = AW'($urandom_range(0, 1023));
        frame_len = LW'(5);
      end
    end
    #1;
    start = 1'b0;
    chk({name, "_words_sent"}, 32'(words_sent), 32'(v.len));
    chk({name, "_reads"}, 32'(n_rd), 32'(v.len));
    chk({name, "_handshakes"}, 32'(n_hs), 32'(v.len));
    chk({name, "_left_over"}, 32'(exp_q.size()), 0);
    if (v.e_rd != -2) chk({name, "_first_rd_cyc"}, 32'(first_rd), 32'(v.e_rd));
    if (v.e_valid != -2) chk({name, "_first_valid_cyc"}, 32'(first_valid), 32'(v.e_valid));
    if (v.e_done != -2) chk({name, "_done_cyc"}, 32'(done_rel), 32'(v.e_done));
  endtask

  vec_t tbl[8];
  vec_t rv;
  int   k;

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    frame_len = '0;
    for (int i = 0; i < 1024; i++) mem[i] = DW'(16'h1000 + i);

    tbl[0] = '{10'h010, 10'd4,  0, -1,  1,  3,  7};  // basic 4-word frame
    tbl[1] = '{10'h123, 10'd1,  0, -1,  1,  3,  4};  // single word
    tbl[2] = '{10'h200, 10'd0,  0, -1, -1, -1,  1};  // empty frame
    tbl[3] = '{10'h050, 10'd8,  1, -1,  1,  3, -2};  // 1,0,0 backpressure
    tbl[4] = '{10'h3FE, 10'd4,  0, -1,  1,  3,  7};  // address wrap
    tbl[5] = '{10'h040, 10'd10, 0,  4,  1,  3, 13};  // start ignored mid-stream
    tbl[6] = '{10'h300, 10'd3,  0,  6,  1,  3,  6};  // start ignored in done cycle
    tbl[7] = '{10'h000, 10'd20, 2, -1,  1,  3, -2};  // random backpressure

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_words_sent", 32'(words_sent), 0);
    chk("rst_rd_en", 32'(buf_rd_en), 0);
    chk("rst_rd_addr", 32'(buf_rd_addr), 0);
    chk("rst_tvalid", 32'(m_if.tvalid), 0);
    chk("rst_tlast", 32'(m_if.tlast), 0);
    chk("rst_tdata", 32'(m_if.tdata), 0);
    @(posedge aclk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset after three of six words, then a clean 2-word frame.
    rmode = 0;
    @(posedge aclk);
    #1;
    start     = 1'b1;
    base_addr = 10'h100;
    frame_len = 10'd6;
    @(posedge aclk);
    #1;
    start = 1'b0;
    k = 0;
    while (n_hs < 3 && k < 100) begin
      @(posedge aclk);
      k++;
    end
    chk("rst_seq_reached_3", 32'(n_hs >= 3), 1);
    #1;
    rst = 1'b1;
    @(posedge aclk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_words_sent", 32'(words_sent), 0);
    repeat (4) @(posedge aclk);
    rv = '{10'h080, 10'd2, 0, -1, 1, 3, 5};
    run_vec(rv, "after_rst");

    // Randomized frames against the model.
    for (int i = 0; i < 25; i++) begin
      rv.base    = AW'($urandom_range(0, 1023));
      rv.len     = LW'($urandom_range(0, 40));
      rv.mode    = 2;
      rv.spur    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1;
      rv.e_rd    = (rv.len == 0) ? -1 : 1;
      rv.e_valid = (rv.len == 0) ? -1 : 3;
      rv.e_done  = (rv.len == 0) ? 1 : -2;
      run_vec(rv, $sformatf("rand%0d", i));
    end

    repeat (3) @(posedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
